// File: rtl/jls_neighbor_gen.sv
// JPEG-LS neighbourhood generator: turns a raster pixel stream into Rx/Ra/Rb/Rc/Rd
// plus gradients D1..D3, with image-boundary substitution and a fixed 2-cycle latency.
module jls_neighbor_gen #(
  parameter int DATA_W    = 16,
  parameter int MAX_WIDTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   img_width,
  input  logic [15:0]       img_height,
  input  logic              sof,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic [DATA_W-1:0] Rx,
  output logic [DATA_W-1:0] Ra,
  output logic [DATA_W-1:0] Rb,
  output logic [DATA_W-1:0] Rc,
  output logic [DATA_W-1:0] Rd,
  output logic [DATA_W-1:0] D1,
  output logic [DATA_W-1:0] D2,
  output logic [DATA_W-1:0] D3,
  output logic              data_en,
  output logic              eol,
  output logic              frame_done
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [ADDR_W:0]   ONE_W = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]       ONE_H = 16'd1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [15:0]         row_q, row_d;
  logic [ADDR_W:0]     width_q, width_d;
  logic [15:0]         height_q, height_d;

  logic                s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]   s1_pix_q, s1_pix_d;
  logic                s1_first_row_q, s1_first_row_d;
  logic                s1_first_col_q, s1_first_col_d;
  logic                s1_last_col_q, s1_last_col_d;
  logic                s1_last_pix_q, s1_last_pix_d;

  logic [DATA_W-1:0]   left_q, left_d;
  logic [DATA_W-1:0]   up_b_q, up_b_d;
  logic [DATA_W-1:0]   up_c_q, up_c_d;
  logic [DATA_W-1:0]   first_prev1_q, first_prev1_d;
  logic [DATA_W-1:0]   first_prev2_q, first_prev2_d;

  logic [DATA_W-1:0]   rx_q, rx_d, ra_q, ra_d, rb_q, rb_d, rc_q, rc_d, rd_q, rd_d;
  logic [DATA_W-1:0]   d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic                data_en_q, data_en_d, eol_q, eol_d, frame_done_q, frame_done_d;

  logic [DATA_W-1:0]   mem [0:MAX_WIDTH-1];
  logic [DATA_W-1:0]   rd_data_q;

  logic                sof_in, accept, cur_last_col, cur_last_row;
  logic [ADDR_W-1:0]   cur_col;
  logic [15:0]         cur_row, cur_height;
  logic [ADDR_W:0]     cur_width;
  logic [DATA_W-1:0]   na, nb, nc, nd;

  // Stage 0: position tracking; a qualified sof always restarts at (0,0) with fresh dimensions.
  always_comb begin
    sof_in       = pix_valid && sof;
    accept       = pix_valid && (sof || state_q == ACTIVE);
    cur_col      = sof_in ? '0 : col_q;
    cur_row      = sof_in ? '0 : row_q;
    cur_width    = sof_in ? img_width : width_q;
    cur_height   = sof_in ? img_height : height_q;
    cur_last_col = ({1'b0, cur_col} == cur_width - ONE_W);
    cur_last_row = (cur_row == cur_height - ONE_H);

    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    width_d  = width_q;
    height_d = height_q;

    s1_valid_d     = accept;
    s1_pix_d       = s1_pix_q;
    s1_first_row_d = s1_first_row_q;
    s1_first_col_d = s1_first_col_q;
    s1_last_col_d  = s1_last_col_q;
    s1_last_pix_d  = s1_last_pix_q;

    if (accept) begin
      width_d        = cur_width;
      height_d       = cur_height;
      s1_pix_d       = pix_in;
      s1_first_row_d = (cur_row == '0);
      s1_first_col_d = (cur_col == '0);
      s1_last_col_d  = cur_last_col;
      s1_last_pix_d  = cur_last_col && cur_last_row;
      if (cur_last_col && cur_last_row) begin
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
      end else if (cur_last_col) begin
        state_d = ACTIVE;
        col_d   = '0;
        row_d   = cur_row + ONE_H;
      end else begin
        state_d = ACTIVE;
        col_d   = cur_col + ONE_A;
        row_d   = cur_row;
      end
    end
  end

  // Line buffer: x[r][c] overwrites slot c while slot c+1 (still row r-1) is prefetched as Rd.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[cur_col] <= pix_in;
      rd_data_q    <= mem[cur_col + ONE_A];
    end
  end

  // Stage 1: boundary substitution and the sliding upper-row window.
  always_comb begin
    if (s1_first_row_q) begin
      nb = '0;
      nc = '0;
      nd = '0;
      na = s1_first_col_q ? '0 : left_q;
    end else if (s1_first_col_q) begin
      nb = first_prev1_q;
      na = first_prev1_q;
      nc = first_prev2_q;
      nd = s1_last_col_q ? first_prev1_q : rd_data_q;
    end else begin
      nb = up_b_q;
      nc = up_c_q;
      na = left_q;
      nd = s1_last_col_q ? up_b_q : rd_data_q;
    end

    left_d        = left_q;
    up_b_d        = up_b_q;
    up_c_d        = up_c_q;
    first_prev1_d = first_prev1_q;
    first_prev2_d = first_prev2_q;
    rx_d = rx_q;  ra_d = ra_q;  rb_d = rb_q;  rc_d = rc_q;  rd_d = rd_q;
    d1_d = d1_q;  d2_d = d2_q;  d3_d = d3_q;
    data_en_d    = s1_valid_q;
    eol_d        = s1_valid_q && s1_last_col_q;
    frame_done_d = s1_valid_q && s1_last_pix_q;

    if (s1_valid_q) begin
      left_d = s1_pix_q;
      up_c_d = nb;
      up_b_d = rd_data_q;
      if (s1_first_col_q) begin
        first_prev1_d = s1_pix_q;
        first_prev2_d = s1_first_row_q ? '0 : first_prev1_q;
      end
      rx_d = s1_pix_q;
      ra_d = na;
      rb_d = nb;
      rc_d = nc;
      rd_d = nd;
      d1_d = nd - nb;
      d2_d = nb - nc;
      d3_d = nc - na;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      width_q        <= '0;
      height_q       <= '0;
      s1_valid_q     <= 1'b0;
      s1_pix_q       <= '0;
      s1_first_row_q <= 1'b0;
      s1_first_col_q <= 1'b0;
      s1_last_col_q  <= 1'b0;
      s1_last_pix_q  <= 1'b0;
      left_q         <= '0;
      up_b_q         <= '0;
      up_c_q         <= '0;
      first_prev1_q  <= '0;
      first_prev2_q  <= '0;
      rx_q           <= '0;
      ra_q           <= '0;
      rb_q           <= '0;
      rc_q           <= '0;
      rd_q           <= '0;
      d1_q           <= '0;
      d2_q           <= '0;
      d3_q           <= '0;
      data_en_q      <= 1'b0;
      eol_q          <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      width_q        <= width_d;
      height_q       <= height_d;
      s1_valid_q     <= s1_valid_d;
      s1_pix_q       <= s1_pix_d;
      s1_first_row_q <= s1_first_row_d;
      s1_first_col_q <= s1_first_col_d;
      s1_last_col_q  <= s1_last_col_d;
      s1_last_pix_q  <= s1_last_pix_d;
      left_q         <= left_d;
      up_b_q         <= up_b_d;
      up_c_q         <= up_c_d;
      first_prev1_q  <= first_prev1_d;
      first_prev2_q  <= first_prev2_d;
      rx_q           <= rx_d;
      ra_q           <= ra_d;
      rb_q           <= rb_d;
      rc_q           <= rc_d;
      rd_q           <= rd_d;
      d1_q           <= d1_d;
      d2_q           <= d2_d;
      d3_q           <= d3_d;
      data_en_q      <= data_en_d;
      eol_q          <= eol_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign Rx         = rx_q;
  assign Ra         = ra_q;
  assign Rb         = rb_q;
  assign Rc         = rc_q;
  assign Rd         = rd_q;
  assign D1         = d1_q;
  assign D2         = d2_q;
  assign D3         = d3_q;
  assign data_en    = data_en_q;
  assign eol        = eol_q;
  assign frame_done = frame_done_q;

endmodule
